// File: rtl/uart_pkg.sv
// Shared definitions for the UART echo buffer: FSM state encodings, ASCII
// constants and the occupancy-counter width helper.
package uart_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE      = 2'd0;
  localparam state_t ST_SEND      = 2'd1;
  localparam state_t ST_WAIT_DONE = 2'd2;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  // An occupancy counter must represent 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with first-word-fall-through head, full/empty flags and
// occupancy count. The caller must not push when full unless it also pops.
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = cnt_width(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_en_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [CNT_W-1:0]  count_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q;
  logic [AW-1:0]     rd_ptr_q;
  logic [CNT_W-1:0]  count_q;

  assign full_o    = (count_q == CNT_W'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
  assign rd_data_o = mem_q[rd_ptr_q];

  // NOTE: storage is deliberately not reset; pointers and count define validity.
  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_ptr_q] <= wr_data_i;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en_i) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (rd_en_i) rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({wr_en_i, rd_en_i})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_echo_buffer.sv
// Buffered UART echo: queues received words and replays them through a start/done
// handshake with watchdog, sticky errors and LEDs. ECHO_CRLF_EN appends LF after CR.
module uart_echo_buffer
  import uart_pkg::*;
#(
  parameter int          DATA_W     = 8,
  parameter int          DEPTH      = 16,
  parameter int unsigned TX_TIMEOUT = 1000000,
  parameter int          CNT_W      = cnt_width(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              tx_done,
  input  logic              clear_err,
  output logic              tx_start,
  output logic [DATA_W-1:0] tx_data,
  output logic [CNT_W-1:0]  fifo_count,
  output logic              overflow,
  output logic              tx_err,
  output logic              led_rx_n,
  output logic              led_tx_n
);

  localparam logic [31:0] WD_LAST = (TX_TIMEOUT == 0) ? 32'd0 : 32'(TX_TIMEOUT - 1);

  state_t            state_q, state_d;
  logic              tx_start_q, tx_start_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic [31:0]       wd_q, wd_d;
  logic              overflow_q, overflow_d;
  logic              tx_err_q, tx_err_d;
  logic              led_rx_q, led_rx_d;
  logic              led_tx_q, led_tx_d;

  logic              push, pop, rx_ok, full, empty, wd_fire;
  logic [DATA_W-1:0] push_data, head;

  uart_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .CNT_W  (CNT_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (push),
    .wr_data_i (push_data),
    .rd_en_i   (pop),
    .rd_data_o (head),
    .full_o    (full),
    .empty_o   (empty),
    .count_o   (fifo_count)
  );

  assign pop = (state_q == ST_IDLE) && !empty;

`ifdef ECHO_CRLF_EN
  logic             lf_pend_q, lf_pend_d;
  logic             is_cr;
  logic [CNT_W:0]   free_slots;

  assign is_cr      = (rx_data == DATA_W'(ASCII_CR));
  assign free_slots = (CNT_W+1)'(DEPTH) - {1'b0, fifo_count} + (CNT_W+1)'(pop);
  assign lf_pend_d  = rx_ok && is_cr;

  // The LF slot was reserved when the CR was accepted, so it always fits.
  always_comb begin
    push      = 1'b0;
    rx_ok     = 1'b0;
    push_data = rx_data;
    if (lf_pend_q) begin
      push      = 1'b1;
      push_data = DATA_W'(ASCII_LF);
    end else if (rx_valid) begin
      rx_ok = is_cr ? (free_slots >= (CNT_W+1)'(2)) : (!full || pop);
      push  = rx_ok;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) lf_pend_q <= 1'b0;
    else     lf_pend_q <= lf_pend_d;
  end
`else
  assign rx_ok     = rx_valid && (!full || pop);
  assign push      = rx_ok;
  assign push_data = rx_data;
`endif

  assign wd_fire = (state_q == ST_WAIT_DONE) && !tx_done && (TX_TIMEOUT != 0) &&
                   (wd_q == WD_LAST);

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path infers a latch.
    state_d    = state_q;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    wd_d       = wd_q;
    led_tx_d   = led_tx_q;
    case (state_q)
      ST_IDLE: begin
        if (!empty) begin
          tx_data_d  = head;
          tx_start_d = 1'b1;
          state_d    = ST_SEND;
        end
      end
      ST_SEND: begin
        wd_d    = '0;
        state_d = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (tx_done) begin
          led_tx_d = ~led_tx_q;
          state_d  = ST_IDLE;
        end else if (wd_fire) begin
          state_d = ST_IDLE;
        end else begin
          wd_d = wd_q + 32'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Set events override a simultaneous clear.
  assign overflow_d = (overflow_q & ~clear_err) | (rx_valid & ~rx_ok);
  assign tx_err_d   = (tx_err_q & ~clear_err) | wd_fire;
  assign led_rx_d   = led_rx_q ^ rx_ok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      wd_q       <= '0;
      overflow_q <= 1'b0;
      tx_err_q   <= 1'b0;
      led_rx_q   <= 1'b1;
      led_tx_q   <= 1'b1;
    end else begin
      state_q    <= state_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      wd_q       <= wd_d;
      overflow_q <= overflow_d;
      tx_err_q   <= tx_err_d;
      led_rx_q   <= led_rx_d;
      led_tx_q   <= led_tx_d;
    end
  end

  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;
  assign overflow = overflow_q;
  assign tx_err   = tx_err_q;
  assign led_rx_n = led_rx_q;
  assign led_tx_n = led_tx_q;

endmodule
